// File: rtl/aes_guard_pkg.sv
// aes_guard_pkg: shared state encoding, fault codes and block width for the AES ciphertext release guard.
// No ports. Exports the state_e FSM encoding, FC_NONE/FC_MISMATCH/FC_TIMEOUT and BLK_W.
package aes_guard_pkg;
   localparam int BLK_W = 128;
   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISMATCH = 2'b01;
   localparam logic [1:0] FC_TIMEOUT  = 2'b10;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_A, S_WAIT_B, S_CHECK, S_OUT, S_LOCKED} state_e;
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/aes_guard_skew_timer.sv
// aes_guard_skew_timer: counts cycles spent waiting for the second core's result.
// Ports: clk_i/rst_i clock and async reset; clr_i zeroes the count; en_i increments it;
// expired_o is high in the cycle whose increment would reach MAX_SKEW.
module aes_guard_skew_timer
   import aes_guard_pkg::*;
#(
   parameter int unsigned MAX_SKEW = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [7:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? 8'd0 : en_i ? sat_inc8(cnt_q) : cnt_q;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   // Flagging one count early lets a transfer arriving in the expiring cycle still win.
   assign expired_o = (cnt_q == 8'(MAX_SKEW - 1));
endmodule

// File: rtl/aes_ct_release_guard.sv
// aes_ct_release_guard: compares duplicated AES ciphertexts and releases only matching results.
// Ports: clk_i/rst_i clock and async reset; ct_a_*/ct_b_* valid/ready inputs from the two cores;
// ct_out_* valid/ready release port (data zero when not valid); fault_o one-cycle pulse,
// fault_code_o last fault cause, fault_count_o saturating fault count, locked_o permanent lockout.
module aes_ct_release_guard
   import aes_guard_pkg::*;
#(
   parameter int unsigned MAX_SKEW    = 16,
   parameter int unsigned FAULT_LIMIT = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [BLK_W-1:0] ct_a_i,
   input  logic             ct_a_valid_i,
   output logic             ct_a_ready_o,
   input  logic [BLK_W-1:0] ct_b_i,
   input  logic             ct_b_valid_i,
   output logic             ct_b_ready_o,
   output logic [BLK_W-1:0] ct_out_o,
   output logic             ct_out_valid_o,
   input  logic             ct_out_ready_i,
   output logic             fault_o,
   output logic [1:0]       fault_code_o,
   output logic [7:0]       fault_count_o,
   output logic             locked_o
);
   state_e           state_q, state_d;
   logic [BLK_W-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
   logic             fault_q, fault_d;
   logic [1:0]       fault_code_q, fault_code_d, flt_code;
   logic [7:0]       fault_count_q, fault_count_d;
   logic             tmr_clr, tmr_en, tmr_expired, flt;
   aes_guard_skew_timer #(.MAX_SKEW(MAX_SKEW)) u_skew_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expired_o(tmr_expired)
   );
   always_comb begin
      state_d       = state_q;
      cap_a_d       = cap_a_q;
      cap_b_d       = cap_b_q;
      fault_d       = 1'b0;
      fault_code_d  = fault_code_q;
      fault_count_d = fault_count_q;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;
      flt           = 1'b0;
      flt_code      = FC_NONE;
      case (state_q)
         S_IDLE: begin
            tmr_clr = 1'b1;
            if (ct_a_valid_i) cap_a_d = ct_a_i;
            if (ct_b_valid_i) cap_b_d = ct_b_i;
            state_d = (ct_a_valid_i && ct_b_valid_i) ? S_CHECK :
                      ct_a_valid_i ? S_WAIT_B : ct_b_valid_i ? S_WAIT_A : S_IDLE;
         end
         S_WAIT_A: begin
            tmr_en = 1'b1;
            if (ct_a_valid_i) begin
               cap_a_d = ct_a_i;
               state_d = S_CHECK;
            end else if (tmr_expired) begin
               flt      = 1'b1;
               flt_code = FC_TIMEOUT;
            end
         end
         S_WAIT_B: begin
            tmr_en = 1'b1;
            if (ct_b_valid_i) begin
               cap_b_d = ct_b_i;
               state_d = S_CHECK;
            end else if (tmr_expired) begin
               flt      = 1'b1;
               flt_code = FC_TIMEOUT;
            end
         end
         S_CHECK: begin
            if (cap_a_q == cap_b_q) begin
               state_d = S_OUT;
            end else begin
               flt      = 1'b1;
               flt_code = FC_MISMATCH;
            end
         end
         S_OUT: begin
            if (ct_out_ready_i) begin
               cap_a_d = '0;
               cap_b_d = '0;
               state_d = S_IDLE;
            end
         end
         S_LOCKED: state_d = S_LOCKED;
         // An illegal encoding is treated as tampering and locks the block.
         default:  state_d = S_LOCKED;
      endcase
      if (flt) begin
         fault_d       = 1'b1;
         fault_code_d  = flt_code;
         fault_count_d = sat_inc8(fault_count_q);
         cap_a_d       = '0;
         cap_b_d       = '0;
         state_d       = (fault_count_d >= 8'(FAULT_LIMIT)) ? S_LOCKED : S_IDLE;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cap_a_q       <= '0;
         cap_b_q       <= '0;
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         fault_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cap_a_q       <= cap_a_d;
         cap_b_q       <= cap_b_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         fault_count_q <= fault_count_d;
      end
   end
   // Outputs decode only registered state, so no input reaches an output combinationally.
   assign ct_a_ready_o   = (state_q == S_IDLE) || (state_q == S_WAIT_A);
   assign ct_b_ready_o   = (state_q == S_IDLE) || (state_q == S_WAIT_B);
   assign ct_out_valid_o = (state_q == S_OUT);
   assign ct_out_o       = ct_out_valid_o ? cap_a_q : '0;
   assign locked_o       = (state_q == S_LOCKED);
   assign fault_o        = fault_q;
   assign fault_code_o   = fault_code_q;
   assign fault_count_o  = fault_count_q;
endmodule

// File: tb/tb_aes_ct_release_guard.sv
// tb_aes_ct_release_guard: directed self-checking bench for the ciphertext release guard.
module tb_aes_ct_release_guard;
   localparam logic [127:0] K1 = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] K2 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] K3 = 128'hDEADBEEF0123456789ABCDEFFEEDC0DE;
   logic         clk = 1'b0;
   logic         rst, ct_a_valid, ct_b_valid, ct_out_ready;
   logic [127:0] ct_a, ct_b;
   logic         ct_a_ready, ct_b_ready, ct_out_valid, fault, locked;
   logic [127:0] ct_out;
   logic [1:0]   fault_code;
   logic [7:0]   fault_count;
   int           n_tests = 0;
   int           n_fail = 0;
   aes_ct_release_guard #(.MAX_SKEW(16), .FAULT_LIMIT(3)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ct_a_i        (ct_a),
      .ct_a_valid_i  (ct_a_valid),
      .ct_a_ready_o  (ct_a_ready),
      .ct_b_i        (ct_b),
      .ct_b_valid_i  (ct_b_valid),
      .ct_b_ready_o  (ct_b_ready),
      .ct_out_o      (ct_out),
      .ct_out_valid_o(ct_out_valid),
      .ct_out_ready_i(ct_out_ready),
      .fault_o       (fault),
      .fault_code_o  (fault_code),
      .fault_count_o (fault_count),
      .locked_o      (locked)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_tests++;
      if ({ct_a_ready, ct_b_ready, ct_out_valid, fault, locked} !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 11000", {ct_a_ready, ct_b_ready, ct_out_valid, fault, locked});
      end
      n_tests++;
      if (ct_out !== 128'd0) begin
         n_fail++;
         $display("FAIL reset_ct_out: got %h want 0", ct_out);
      end
      n_tests++;
      if ({fault_code, fault_count} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_fault_regs: got code %b count %0d want 00/0", fault_code, fault_count);
      end
      step();
      rst = 1'b0;
      step();
      n_tests++;
      if ({ct_a_ready, ct_b_ready, ct_out_valid} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %b want 110", {ct_a_ready, ct_b_ready, ct_out_valid});
      end
   endtask
   task automatic test_same_cycle();
      ct_a = K1;
      ct_b = K1;
      ct_a_valid = 1'b1;
      ct_b_valid = 1'b1;
      ct_out_ready = 1'b1;
      step();
      ct_a_valid = 1'b0;
      ct_b_valid = 1'b0;
      n_tests++;
      if ({ct_a_ready, ct_b_ready, ct_out_valid, fault} !== 4'b0000) begin
         n_fail++;
         $display("FAIL same_check_state: got %b want 0000", {ct_a_ready, ct_b_ready, ct_out_valid, fault});
      end
      step();
      n_tests++;
      if ({ct_out_valid, fault} !== 2'b10 || ct_out !== K1) begin
         n_fail++;
         $display("FAIL same_release: got valid %b fault %b data %h want 1/0/%h", ct_out_valid, fault, ct_out, K1);
      end
      step();
      n_tests++;
      if ({ct_a_ready, ct_b_ready, ct_out_valid, fault} !== 4'b1100 || ct_out !== 128'd0) begin
         n_fail++;
         $display("FAIL same_after_handshake: got %b data %h want 1100/0", {ct_a_ready, ct_b_ready, ct_out_valid, fault}, ct_out);
      end
   endtask
   task automatic test_skewed();
      logic bad;
      ct_out_ready = 1'b0;
      ct_a = K2;
      ct_b = K2;
      ct_a_valid = 1'b1;
      step();
      ct_a_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ({ct_a_ready, ct_b_ready, fault} !== 3'b010) bad = 1'b1;
         step();
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL skew_wait_b_readies: got %b want 010", {ct_a_ready, ct_b_ready, fault});
      end
      ct_b_valid = 1'b1;
      step();
      ct_b_valid = 1'b0;
      n_tests++;
      if ({ct_a_ready, ct_b_ready, ct_out_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL skew_check_state: got %b want 000", {ct_a_ready, ct_b_ready, ct_out_valid});
      end
      step();
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if ({ct_a_ready, ct_b_ready, ct_out_valid, fault} !== 4'b0010 || ct_out !== K2) bad = 1'b1;
         if (i < 2) step();
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL skew_hold_stable: got %b data %h want 0010/%h", {ct_a_ready, ct_b_ready, ct_out_valid, fault}, ct_out, K2);
      end
      ct_out_ready = 1'b1;
      step();
      n_tests++;
      if ({ct_a_ready, ct_b_ready, ct_out_valid} !== 3'b110 || ct_out !== 128'd0) begin
         n_fail++;
         $display("FAIL skew_readies_return: got %b data %h want 110/0", {ct_a_ready, ct_b_ready, ct_out_valid}, ct_out);
      end
   endtask
   task automatic test_b_first();
      ct_out_ready = 1'b1;
      ct_b = K3;
      ct_b_valid = 1'b1;
      step();
      ct_b_valid = 1'b0;
      step();
      n_tests++;
      if ({ct_a_ready, ct_b_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL bfirst_wait_a_readies: got %b want 10", {ct_a_ready, ct_b_ready});
      end
      ct_a = K3;
      ct_a_valid = 1'b1;
      step();
      ct_a_valid = 1'b0;
      step();
      n_tests++;
      if (ct_out_valid !== 1'b1 || ct_out !== K3) begin
         n_fail++;
         $display("FAIL bfirst_release: got valid %b data %h want 1/%h", ct_out_valid, ct_out, K3);
      end
      step();
   endtask
   task automatic test_skew_boundary();
      ct_a = K1;
      ct_b = K1;
      ct_a_valid = 1'b1;
      step();
      ct_a_valid = 1'b0;
      repeat (15) step();
      n_tests++;
      if ({ct_a_ready, ct_b_ready, fault} !== 3'b010) begin
         n_fail++;
         $display("FAIL boundary_still_waiting: got %b want 010", {ct_a_ready, ct_b_ready, fault});
      end
      ct_b_valid = 1'b1;
      step();
      ct_b_valid = 1'b0;
      n_tests++;
      if ({ct_a_ready, ct_b_ready, fault} !== 3'b000) begin
         n_fail++;
         $display("FAIL boundary_transfer_wins: got %b want 000", {ct_a_ready, ct_b_ready, fault});
      end
      step();
      n_tests++;
      if (ct_out_valid !== 1'b1 || ct_out !== K1 || fault_count !== 8'd0) begin
         n_fail++;
         $display("FAIL boundary_release: got valid %b data %h count %0d want 1/%h/0", ct_out_valid, ct_out, fault_count, K1);
      end
      step();
   endtask
   task automatic test_mismatch();
      ct_a = K1;
      ct_b = K1 ^ 128'h1;
      ct_a_valid = 1'b1;
      ct_b_valid = 1'b1;
      step();
      ct_a_valid = 1'b0;
      ct_b_valid = 1'b0;
      step();
      n_tests++;
      if ({fault, fault_code, ct_out_valid, ct_a_ready, ct_b_ready, locked} !== 7'b1010110 || fault_count !== 8'd1) begin
         n_fail++;
         $display("FAIL mismatch_fault: got f/code/v/ra/rb/l %b count %0d want 1010110/1", {fault, fault_code, ct_out_valid, ct_a_ready, ct_b_ready, locked}, fault_count);
      end
      step();
      n_tests++;
      if ({fault, fault_code, ct_out_valid} !== 4'b0010) begin
         n_fail++;
         $display("FAIL mismatch_pulse_end: got f/code/v %b want 0010", {fault, fault_code, ct_out_valid});
      end
   endtask
   task automatic test_timeout();
      logic bad;
      ct_a = K2;
      ct_a_valid = 1'b1;
      step();
      ct_a_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (fault !== 1'b0 || ct_b_ready !== 1'b1) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL timeout_early: got fault %b rb %b want 0/1", fault, ct_b_ready);
      end
      step();
      n_tests++;
      if ({fault, fault_code, ct_a_ready, ct_b_ready, ct_out_valid, locked} !== 7'b1101100 || fault_count !== 8'd2) begin
         n_fail++;
         $display("FAIL timeout_fault: got f/code/ra/rb/v/l %b count %0d want 1101100/2", {fault, fault_code, ct_a_ready, ct_b_ready, ct_out_valid, locked}, fault_count);
      end
      step();
      n_tests++;
      if (fault !== 1'b0 || fault_code !== 2'b10) begin
         n_fail++;
         $display("FAIL timeout_pulse_end: got fault %b code %b want 0/10", fault, fault_code);
      end
   endtask
   task automatic test_lockout();
      logic bad;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      for (int k = 1; k <= 3; k++) begin
         ct_a = K3;
         ct_b = K3 ^ (128'h1 << (k * 40));
         ct_a_valid = 1'b1;
         ct_b_valid = 1'b1;
         step();
         ct_a_valid = 1'b0;
         ct_b_valid = 1'b0;
         step();
         n_tests++;
         if (fault !== 1'b1 || fault_count !== 8'(k) || locked !== (k == 3) || ct_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_mismatch_%0d: got fault %b count %0d locked %b valid %b want 1/%0d/%b/0", k, fault, fault_count, locked, ct_out_valid, k, k == 3);
         end
      end
      ct_a = K1;
      ct_b = K1;
      ct_a_valid = 1'b1;
      ct_b_valid = 1'b1;
      ct_out_ready = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if ({ct_a_ready, ct_b_ready, ct_out_valid, fault, locked} !== 5'b00001 || ct_out !== 128'd0 || fault_count !== 8'd3) bad = 1'b1;
      end
      ct_a_valid = 1'b0;
      ct_b_valid = 1'b0;
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL lock_hold: got %b data %h count %0d want 00001/0/3", {ct_a_ready, ct_b_ready, ct_out_valid, fault, locked}, ct_out, fault_count);
      end
      rst = 1'b1;
      #2;
      n_tests++;
      if ({ct_a_ready, ct_b_ready, locked, fault_code} !== 5'b11000 || fault_count !== 8'd0) begin
         n_fail++;
         $display("FAIL lock_rst_clear: got ra/rb/l/code %b count %0d want 11000/0", {ct_a_ready, ct_b_ready, locked, fault_code}, fault_count);
      end
      step();
      rst = 1'b0;
      step();
   endtask
   task automatic test_reset_in_out();
      logic bad;
      ct_out_ready = 1'b0;
      ct_a = K2;
      ct_b = K2;
      ct_a_valid = 1'b1;
      ct_b_valid = 1'b1;
      step();
      ct_a_valid = 1'b0;
      ct_b_valid = 1'b0;
      step();
      n_tests++;
      if (ct_out_valid !== 1'b1 || ct_out !== K2) begin
         n_fail++;
         $display("FAIL rstout_reach_out: got valid %b data %h want 1/%h", ct_out_valid, ct_out, K2);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (ct_out_valid !== 1'b0 || ct_out !== 128'd0) begin
         n_fail++;
         $display("FAIL rstout_async_drop: got valid %b data %h want 0/0", ct_out_valid, ct_out);
      end
      step();
      rst = 1'b0;
      ct_out_ready = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if ({ct_a_ready, ct_b_ready, ct_out_valid} !== 3'b110 || ct_out !== 128'd0) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL rstout_no_release: got %b data %h want 110/0", {ct_a_ready, ct_b_ready, ct_out_valid}, ct_out);
      end
   endtask
   initial begin
      rst = 1'b0;
      ct_a = '0;
      ct_b = '0;
      ct_a_valid = 1'b0;
      ct_b_valid = 1'b0;
      ct_out_ready = 1'b0;
      #1;
      test_reset();
      test_same_cycle();
      test_skewed();
      test_b_first();
      test_skew_boundary();
      test_mismatch();
      test_timeout();
      test_lockout();
      test_reset_in_out();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_ct_release_guard.md
# aes_ct_release_guard

Downstream stage of the redundant AES datapath. Takes the two 128-bit ciphertexts produced by the duplicated AES-128 cores and compares them. On a match it releases the ciphertext over a valid/ready handshake. On a mismatch or skew timeout it suppresses the output, zeroizes the captured copies, raises a fault, and locks permanently after a programmable number of faults.

## Interface
- `MAX_SKEW`, 16: maximum cycles allowed between the two cores' valid strobes (1..255).
- `FAULT_LIMIT`, 3: fault count at which the block enters lockout (1..255).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ct_a`  in  128  ciphertext from core A.
- `ct_a_valid`  in  1  core A result valid.
- `ct_a_ready`  out  1  guard accepts core A result.
- `ct_b`  in  128  ciphertext from core B.
- `ct_b_valid`  in  1  core B result valid.
- `ct_b_ready`  out  1  guard accepts core B result.
- `ct_out`  out  128  released ciphertext; zero whenever `ct_out_valid` = 0.
- `ct_out_valid`  out  1  released ciphertext valid.
- `ct_out_ready`  in  1  downstream accepts.
- `fault`  out  1  one-cycle fault pulse.
- `fault_code`  out  2  01 = mismatch, 10 = skew timeout, 00 = none. Held until the next fault.
- `fault_count`  out  8  saturating fault counter.
- `locked`  out  1  lockout active.

## Operation
- A transfer on side X completes on a cycle where `ct_X_valid` and `ct_X_ready` are both high.
- States: IDLE, WAIT_A, WAIT_B, CHECK, OUT, LOCKED.
- IDLE (both readies = 1):
  - Both sides transfer in the same cycle: capture both, go to CHECK.
  - A only: capture A, clear the skew counter, go to WAIT_B.
  - B only: capture B, clear the skew counter, go to WAIT_A.
- WAIT_B (`ct_b_ready` = 1, `ct_a_ready` = 0); WAIT_A is the mirror image:
  - Skew counter increments every cycle.
  - B transfers: capture B, go to CHECK.
  - Counter reaches `MAX_SKEW` with no transfer: timeout fault.
  - If B transfers in the same cycle the counter hits `MAX_SKEW`, the transfer wins.
- CHECK (both readies = 0): compare all 128 bits.
  - Equal: go to OUT.
  - Unequal: mismatch fault.
- OUT: `ct_out_valid` = 1 and `ct_out` = captured value, both held stable until `ct_out_ready`. On the handshake, zeroize the captures and go to IDLE.
- Fault (mismatch or timeout):
  - Pulse `fault`, update `fault_code`, increment `fault_count` (saturates at 255), zeroize both captures.
  - Go to LOCKED if the new count is ≥ `FAULT_LIMIT`, else IDLE.
  - No ciphertext is ever released on a fault.
- LOCKED: all readies = 0, `ct_out_valid` = 0, `ct_out` = 0, `locked` = 1. The only exit is `rst`.
- Reset mid-operation: every register returns to its reset value immediately; any pending result is discarded without release.

## Timing
- Reset values:
  - State = IDLE.
  - `ct_a_ready` = `ct_b_ready` = 1.
  - `ct_out` = 0, `ct_out_valid` = 0.
  - `fault` = 0, `fault_code` = 00, `fault_count` = 0, `locked` = 0.
  - Captures = 0.
- Latency, both sides valid at edge T: CHECK during cycle T+1, `ct_out_valid` high from edge T+2.
- Latency, skewed arrival: the later capture at edge T gives `ct_out_valid` at T+2.
- `fault` asserts on the edge after CHECK or the timeout cycle, for exactly one cycle.
- `locked` asserts on the same edge as the final `fault`.
- All outputs are registered; no combinational path from inputs to outputs except through the state machine.
- `ct_out_ready` held low: OUT persists indefinitely and no new inputs are accepted.

## Structure
- Shared package `aes_guard_pkg` holds:
  - the state enum;
  - fault code constants `FC_NONE`, `FC_MISMATCH`, `FC_TIMEOUT`;
  - the 128-bit block width constant.
- One natural sub-module: `aes_guard_skew_timer` (clear, enable, `MAX_SKEW` compare, expired flag). Comparator and FSM stay in the top.

## Test plan
- Both valid in the same cycle with `ct_a` = `ct_b` = `128'h3925841D02DC09FBDC118597196A0B32`, `ct_out_ready` = 1 → `ct_out` equals that value, valid exactly 2 cycles later; `fault` never asserts.
- A valid, then B valid 5 cycles later, same value; `ct_out_ready` held low for 3 cycles → data stable throughout; released on the handshake; readies return to 1 the next cycle.
- `ct_b` = `ct_a` XOR `128'h1` → `fault` pulses once, `fault_code` = 01, `fault_count` = 1, `ct_out_valid` stays 0.
- A valid, B silent for 16 cycles → timeout: `fault_code` = 10, state returns to IDLE, `ct_b_ready` = 1.
- Three consecutive mismatches → `locked` = 1 and `fault_count` = 3; readies stay 0 under further valid inputs; `rst` pulse clears everything.
- Assert `rst` while in OUT → `ct_out_valid` drops asynchronously; no release after reset deasserts.
